// File: rtl/multdiv_if.sv
// Bundle of pipeline-side and unit-side signals around the multdiv controller.
// The controller uses the slave modport; the pipeline/unit environment uses master.
interface multdiv_if;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] unit_operandA;
  logic [31:0] unit_operandB;
  logic        mult_start;
  logic        div_start;
  logic [31:0] mult_result;
  logic        mult_exception;
  logic        mult_resultRDY;
  logic [31:0] div_result;
  logic        div_exception;
  logic        div_resultRDY;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    input  mult_result, mult_exception, mult_resultRDY,
    input  div_result, div_exception, div_resultRDY,
    output unit_operandA, unit_operandB, mult_start, div_start,
    output data_result, data_exception, data_resultRDY, busy
  );

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    output mult_result, mult_exception, mult_resultRDY,
    output div_result, div_exception, div_resultRDY,
    input  unit_operandA, unit_operandB, mult_start, div_start,
    input  data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/multdiv_controller.sv
// Sequencer for the shared iterative multiplier/divider of the multdiv stage.
// Optional WAIT timeout is enabled by defining MULTDIV_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no operation in flight
// START | operands latched, one-cycle start to the selected unit
// WAIT  | waiting for the selected unit's resultRDY
// DONE  | captured result presented with data_resultRDY
module multdiv_controller #(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_WIDTH      = 6
) (
  input logic       clock,
  input logic       reset,
  multdiv_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t                state, state_nxt;
  logic [31:0]           opa, opb;
  logic                  op_is_div;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [31:0]           result_q;
  logic                  exception_q;

  logic                  accept;
  logic                  sel_rdy;
  logic                  div_by_zero;
  logic                  timeout_hit;
  logic                  capture;
  logic [31:0]           cap_result;
  logic                  cap_exception;

  assign accept      = bus.ctrl_MULT | bus.ctrl_DIV;
  assign sel_rdy     = op_is_div ? bus.div_resultRDY : bus.mult_resultRDY;
  assign div_by_zero = op_is_div && (opb == 32'd0);

`ifdef MULTDIV_TIMEOUT_EN
  // Fires on the last WAIT cycle so DONE begins TIMEOUT_CYCLES after WAIT entry.
  assign timeout_hit = (cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign timeout_hit        = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0) ^ (^cnt);
`endif

  always_comb begin
    state_nxt     = state;
    capture       = 1'b0;
    cap_result    = 32'd0;
    cap_exception = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = START;
      end
      START: begin
        if (accept) begin
          state_nxt = START;
        end else if (div_by_zero) begin
          state_nxt     = DONE;
          capture       = 1'b1;
          cap_exception = 1'b1;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (accept) begin
          state_nxt = START;
        end else if (sel_rdy) begin
          state_nxt     = DONE;
          capture       = 1'b1;
          cap_result    = op_is_div ? bus.div_result : bus.mult_result;
          cap_exception = op_is_div ? bus.div_exception : bus.mult_exception;
        end else if (timeout_hit) begin
          state_nxt     = DONE;
          capture       = 1'b1;
          cap_exception = 1'b1;
        end
      end
      DONE: begin
        state_nxt = accept ? START : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      opa         <= 32'd0;
      opb         <= 32'd0;
      op_is_div   <= 1'b0;
      cnt         <= '0;
      result_q    <= 32'd0;
      exception_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        opa       <= bus.data_operandA;
        opb       <= bus.data_operandB;
        op_is_div <= ~bus.ctrl_MULT;
        cnt       <= '0;
      end else if (state == WAIT && cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
      if (capture) begin
        result_q    <= cap_result;
        exception_q <= cap_exception;
      end
    end
  end

  assign bus.unit_operandA  = opa;
  assign bus.unit_operandB  = opb;
  assign bus.mult_start     = (state == START) && !op_is_div;
  assign bus.div_start      = (state == START) && op_is_div && (opb != 32'd0);
  assign bus.data_result    = result_q;
  assign bus.data_exception = exception_q;
  assign bus.data_resultRDY = (state == DONE);
  assign bus.busy           = (state != IDLE);

endmodule

// File: tb/tb_multdiv_controller.sv
// Directed bench for multdiv_controller with simple latency models of both units.
module tb_multdiv_controller;
  logic clock;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  multdiv_if bus();

  multdiv_controller #(.TIMEOUT_CYCLES(40), .CNT_WIDTH(6)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // unit models: RDY pulses 'lat' edges after the start pulse is sampled
  logic        mult_en  = 1'b1;
  int          mult_lat = 16;
  int          div_lat  = 8;
  int          m_cnt    = 0;
  int          d_cnt    = 0;
  logic [31:0] m_res    = 32'd0;
  logic [31:0] d_res    = 32'd0;

  always @(posedge clock) begin
    bus.mult_resultRDY <= 1'b0;
    bus.mult_exception <= 1'b0;
    if (bus.mult_start && mult_en) begin
      m_cnt <= mult_lat;
      m_res <= bus.unit_operandA * bus.unit_operandB;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        bus.mult_resultRDY <= 1'b1;
        bus.mult_result    <= m_res;
      end
    end
  end

  always @(posedge clock) begin
    bus.div_resultRDY <= 1'b0;
    bus.div_exception <= 1'b0;
    if (bus.div_start) begin
      d_cnt <= div_lat;
      d_res <= (bus.unit_operandB != 0) ? bus.unit_operandA / bus.unit_operandB : 32'd0;
    end else if (d_cnt != 0) begin
      d_cnt <= d_cnt - 1;
      if (d_cnt == 1) begin
        bus.div_resultRDY <= 1'b1;
        bus.div_result    <= d_res;
      end
    end
  end

  // Drives one ctrl pulse; returns at the negedge of the cycle after the accept edge.
  task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    bus.ctrl_MULT     = m;
    bus.ctrl_DIV      = d;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(negedge clock);
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV  = 1'b0;
  endtask

  task automatic test_reset();
    int n_rdy;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.data_resultRDY !== 1'b0 || bus.mult_start !== 1'b0 ||
        bus.div_start !== 1'b0 || bus.data_result !== 32'd0 || bus.unit_operandA !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b rdy=%b ms=%b ds=%b res=%h opa=%h, expected all 0",
               bus.busy, bus.data_resultRDY, bus.mult_start, bus.div_start, bus.data_result, bus.unit_operandA);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    issue(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.data_resultRDY !== 1'b0 || bus.mult_start !== 1'b0 ||
        bus.unit_operandA !== 32'd0 || bus.unit_operandB !== 32'd0 || bus.data_exception !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_wait: busy=%b rdy=%b ms=%b opa=%h opb=%h exc=%b, expected all 0",
               bus.busy, bus.data_resultRDY, bus.mult_start, bus.unit_operandA, bus.unit_operandB, bus.data_exception);
    end
    @(negedge clock);
    reset = 1'b0;
    n_rdy = 0;
    repeat (30) begin
      @(negedge clock);
      if (bus.data_resultRDY) n_rdy++;
    end
    n_checks++;
    if (n_rdy !== 0) begin
      n_fail++;
      $display("FAIL reset_no_rdy: saw %0d data_resultRDY cycles, expected 0", n_rdy);
    end
  endtask

  task automatic test_mult();
    int idx;
    int n_ms;
    mult_lat = 16;
    issue(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA);
    n_checks++;
    if (bus.mult_start !== 1'b1 || bus.div_start !== 1'b0 || bus.busy !== 1'b1 ||
        bus.unit_operandA !== 32'd7 || bus.unit_operandB !== 32'hFFFF_FFFA) begin
      n_fail++;
      $display("FAIL mult_start_cycle: ms=%b ds=%b busy=%b opa=%h opb=%h, expected 1 0 1 7 fffffffa",
               bus.mult_start, bus.div_start, bus.busy, bus.unit_operandA, bus.unit_operandB);
    end
    n_ms = 1;
    idx  = 0;
    do begin
      @(negedge clock);
      idx++;
      if (bus.mult_start) n_ms++;
    end while (!bus.data_resultRDY && idx < 60);
    n_checks++;
    if (idx !== 18) begin
      n_fail++;
      $display("FAIL mult_latency: data_resultRDY at cycle %0d after accept, expected 18", idx);
    end
    n_checks++;
    if (bus.data_result !== 32'hFFFF_FFD6 || bus.data_exception !== 1'b0) begin
      n_fail++;
      $display("FAIL mult_result: got %h exc=%b, expected ffffffd6 exc=0", bus.data_result, bus.data_exception);
    end
    @(negedge clock);
    n_checks++;
    if (bus.data_resultRDY !== 1'b0 || bus.busy !== 1'b0 || n_ms !== 1) begin
      n_fail++;
      $display("FAIL mult_finish: rdy=%b busy=%b start_pulses=%0d, expected 0 0 1",
               bus.data_resultRDY, bus.busy, n_ms);
    end
  endtask

  task automatic test_div_zero();
    int n_ds;
    issue(1'b0, 1'b1, 32'd100, 32'd0);
    n_ds = bus.div_start ? 1 : 0;
    n_checks++;
    if (bus.data_resultRDY !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL div0_start_cycle: rdy=%b busy=%b, expected 0 1", bus.data_resultRDY, bus.busy);
    end
    @(negedge clock);
    if (bus.div_start) n_ds++;
    n_checks++;
    if (bus.data_resultRDY !== 1'b1 || bus.data_result !== 32'd0 || bus.data_exception !== 1'b1) begin
      n_fail++;
      $display("FAIL div0_done: rdy=%b res=%h exc=%b, expected 1 0 1",
               bus.data_resultRDY, bus.data_result, bus.data_exception);
    end
    @(negedge clock);
    if (bus.div_start) n_ds++;
    n_checks++;
    if (n_ds !== 0 || bus.busy !== 1'b0 || bus.data_resultRDY !== 1'b0) begin
      n_fail++;
      $display("FAIL div0_finish: div_start_cycles=%0d busy=%b rdy=%b, expected 0 0 0",
               n_ds, bus.busy, bus.data_resultRDY);
    end
  endtask

  task automatic test_simultaneous();
    int idx;
    int n_ds;
    mult_lat = 5;
    issue(1'b1, 1'b1, 32'd3, 32'd5);
    n_checks++;
    if (bus.mult_start !== 1'b1 || bus.div_start !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_start: ms=%b ds=%b, expected 1 0", bus.mult_start, bus.div_start);
    end
    n_ds = 0;
    idx  = 0;
    do begin
      @(negedge clock);
      idx++;
      if (bus.div_start) n_ds++;
    end while (!bus.data_resultRDY && idx < 60);
    n_checks++;
    if (!bus.data_resultRDY || bus.data_result !== 32'd15 || n_ds !== 0) begin
      n_fail++;
      $display("FAIL simul_result: rdy=%b res=%0d div_starts=%0d, expected 1 15 0",
               bus.data_resultRDY, bus.data_result, n_ds);
    end
    @(negedge clock);
  endtask

  task automatic test_abort();
    int n_rdy;
    logic [31:0] first_res;
    mult_lat = 16;
    div_lat  = 8;
    issue(1'b0, 1'b1, 32'd9, 32'd3);
    n_checks++;
    if (bus.div_start !== 1'b1 || bus.mult_start !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_div_start: ds=%b ms=%b, expected 1 0", bus.div_start, bus.mult_start);
    end
    repeat (2) @(negedge clock);
    issue(1'b1, 1'b0, 32'd2, 32'd4);
    n_rdy     = 0;
    first_res = 32'hDEAD_BEEF;
    repeat (60) begin
      @(negedge clock);
      if (bus.data_resultRDY) begin
        if (n_rdy == 0) first_res = bus.data_result;
        n_rdy++;
      end
    end
    n_checks++;
    if (n_rdy !== 1 || first_res !== 32'd8) begin
      n_fail++;
      $display("FAIL abort_result: rdy_cycles=%0d res=%0d, expected 1 8", n_rdy, first_res);
    end
  endtask

  task automatic test_back_to_back();
    int idx;
    mult_lat = 4;
    issue(1'b1, 1'b0, 32'd3, 32'd5);
    idx = 0;
    do begin
      @(negedge clock);
      idx++;
    end while (!bus.data_resultRDY && idx < 60);
    n_checks++;
    if (!bus.data_resultRDY || bus.data_result !== 32'd15) begin
      n_fail++;
      $display("FAIL b2b_first: rdy=%b res=%0d, expected 1 15", bus.data_resultRDY, bus.data_result);
    end
    issue(1'b1, 1'b0, 32'd6, 32'd7);
    n_checks++;
    if (bus.mult_start !== 1'b1 || bus.unit_operandA !== 32'd6 || bus.data_resultRDY !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_restart: ms=%b opa=%0d rdy=%b, expected 1 6 0",
               bus.mult_start, bus.unit_operandA, bus.data_resultRDY);
    end
    idx = 0;
    do begin
      @(negedge clock);
      idx++;
    end while (!bus.data_resultRDY && idx < 60);
    n_checks++;
    if (!bus.data_resultRDY || bus.data_result !== 32'd42) begin
      n_fail++;
      $display("FAIL b2b_second: rdy=%b res=%0d, expected 1 42", bus.data_resultRDY, bus.data_result);
    end
    @(negedge clock);
  endtask

  task automatic test_timeout();
    int idx;
    int n_busy;
    mult_en = 1'b0;
    issue(1'b1, 1'b0, 32'd11, 32'd13);
`ifdef MULTDIV_TIMEOUT_EN
    idx = 0;
    do begin
      @(negedge clock);
      idx++;
    end while (!bus.data_resultRDY && idx < 100);
    n_checks++;
    if (idx !== 41 || bus.data_result !== 32'd0 || bus.data_exception !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_done: cycle=%0d res=%h exc=%b, expected 41 0 1",
               idx, bus.data_result, bus.data_exception);
    end
    @(negedge clock);
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_idle: busy=%b, expected 0", bus.busy);
    end
`else
    n_busy = 0;
    idx    = 0;
    repeat (200) begin
      @(negedge clock);
      if (bus.busy) n_busy++;
      if (bus.data_resultRDY) idx++;
    end
    n_checks++;
    if (n_busy !== 200 || idx !== 0) begin
      n_fail++;
      $display("FAIL no_timeout_busy: busy_cycles=%0d rdy_cycles=%0d, expected 200 0", n_busy, idx);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
`endif
    mult_en = 1'b1;
  endtask

  initial begin
    reset             = 1'b1;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = 32'd0;
    bus.data_operandB = 32'd0;
    repeat (2) @(negedge clock);
    test_reset();
    test_mult();
    test_div_zero();
    test_simultaneous();
    test_abort();
    test_back_to_back();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
